// File: rtl/icu_wide.sv
// rtl/icu_wide.sv - W-bit MC14500-style industrial control unit
//
// Purpose: executes the 16-opcode ICU instruction set on a W-bit result
// register. The unit has two stages. The capture stage registers I and
// data. The execute stage decodes the captured opcode.
//
// Optional feature: define ICU_SKIP_EN to enable the SKZ/RTN skip logic.
// Without it, SKZ is a NOP and RTN only pulses rtn.
//
// Ports:
//   clk     in   1  clock, rising edge
//   rst     in   1  synchronous active-high reset
//   I       in   4  opcode from the program sequencer
//   data    in   W  operand from the I/O bus
//   result  out  W  result register RR
//   dout    out  W  store data register
//   write   out  1  store strobe, one cycle
//   jmp     out  1  JMP pulse
//   rtn     out  1  RTN pulse
//   flag_0  out  1  NOPO pulse
//   flag_f  out  1  NOPF pulse

module icu_wide #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   I,
  input  logic [W-1:0] data,
  output logic [W-1:0] result,
  output logic [W-1:0] dout,
  output logic         write,
  output logic         jmp,
  output logic         rtn,
  output logic         flag_0,
  output logic         flag_f
);

  logic [3:0]   inst_q;
  logic [W-1:0] data_q;
  logic         valid_q;
  logic         ien, oen;

  logic [W-1:0] d_gated;
  logic [W-1:0] rr_d, dout_d;
  logic         ien_d, oen_d;
  logic         write_d, jmp_d, rtn_d, flag_0_d, flag_f_d;
  logic         suppress;

`ifdef ICU_SKIP_EN
  logic skip_q, skip_d;
  assign suppress = skip_q;
`else
  assign suppress = 1'b0;
`endif

  assign d_gated = ien ? data_q : '0;

  always_comb begin
    rr_d     = result;
    dout_d   = dout;
    ien_d    = ien;
    oen_d    = oen;
    write_d  = 1'b0;
    jmp_d    = 1'b0;
    rtn_d    = 1'b0;
    flag_0_d = 1'b0;
    flag_f_d = 1'b0;
`ifdef ICU_SKIP_EN
    // A pending skip is consumed by the next executed slot.
    // A suppressed slot cannot re-arm skip, so skips never chain.
    // skip_q is already 0 whenever valid_q is 0 (just out of reset),
    // so clearing by default is safe.
    skip_d   = 1'b0;
`endif
    if (valid_q && !suppress) begin
      unique case (inst_q)
        4'h0: flag_0_d = 1'b1;
        4'h1: rr_d = d_gated;
        4'h2: rr_d = ~d_gated;
        4'h3: rr_d = result & d_gated;
        4'h4: rr_d = result & ~d_gated;
        4'h5: rr_d = result | d_gated;
        4'h6: rr_d = result | ~d_gated;
        4'h7: rr_d = ~(result ^ d_gated);
        4'h8: if (oen) begin
                dout_d  = result;
                write_d = 1'b1;
              end
        4'h9: if (oen) begin
                dout_d  = ~result;
                write_d = 1'b1;
              end
        // Enable loads use the raw operand, so IEN can always be re-enabled.
        4'hA: ien_d = data_q[0];
        4'hB: oen_d = data_q[0];
        4'hC: jmp_d = 1'b1;
        4'hD: begin
                rtn_d = 1'b1;
`ifdef ICU_SKIP_EN
                skip_d = 1'b1;
`endif
              end
        4'hE: begin
`ifdef ICU_SKIP_EN
                if (result == '0) skip_d = 1'b1;
`endif
              end
        4'hF: flag_f_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= 4'h0;
      data_q  <= '0;
      valid_q <= 1'b0;
      result  <= '0;
      dout    <= '0;
      ien     <= 1'b1;
      oen     <= 1'b1;
      write   <= 1'b0;
      jmp     <= 1'b0;
      rtn     <= 1'b0;
      flag_0  <= 1'b0;
      flag_f  <= 1'b0;
`ifdef ICU_SKIP_EN
      skip_q  <= 1'b0;
`endif
    end else begin
      inst_q  <= I;
      data_q  <= data;
      valid_q <= 1'b1;
      result  <= rr_d;
      dout    <= dout_d;
      ien     <= ien_d;
      oen     <= oen_d;
      write   <= write_d;
      jmp     <= jmp_d;
      rtn     <= rtn_d;
      flag_0  <= flag_0_d;
      flag_f  <= flag_f_d;
`ifdef ICU_SKIP_EN
      skip_q  <= skip_d;
`endif
    end
  end

endmodule
